uart_rx: RTL and testbench

- Asynchronous serial (UART 8N1) receiver.
- Oversamples the line with the system clock, detects the start bit, samples 8 data bits LSB-first at mid-bit, and validates the stop bit.
- Presents each good byte on a parallel bus with a one-cycle valid strobe.
- Sits between the external RX pin and byte-consuming logic.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rx_sync_edge.sv | 33 +++
 rtl/uart_rx.sv | 109 ++++++++++
 tb/tb_uart_rx.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART receiver constants, state encoding and bit indices.
// Imported by the receiver top and its synchronizer sub-block.
package uart_pkg;

  localparam int CLK_FREQ_DEF   = 50_000_000;
  localparam int BAUD_RATE_DEF  = 9600;
  localparam int BIT_CYCLES_DEF = CLK_FREQ_DEF / BAUD_RATE_DEF;

  localparam int START_BIT = 0;
  localparam int STOP_BIT  = 9;
  localparam int DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  function automatic int mid_point(input int bit_cycles);
    return bit_cycles / 2 - 1;
  endfunction

endpackage

// File: rtl/uart_rx_sync_edge.sv
// Two-flop synchronizer plus delay flop and falling-edge detector.
// Ports: clk, rst_n, din (async line), dout (synced), fall (1->0 edge).
module uart_rx_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic fall
);
  import uart_pkg::*;

  logic sync1;
  logic sync2;
  logic sync3;

  // Flops preset to 1 so an idle-high line
  // never looks like an edge out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      sync3 <= 1'b1;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign dout = sync2;
  assign fall = !sync2 && sync3;

endmodule

// File: rtl/uart_rx.sv
// UART 8N1 receiver: mid-bit sampling, stop-bit check, byte strobe.
// Ports: s_clk, s_rst_n, data_in (serial), data_rx[7:0], po_flag.
module uart_rx #(
  parameter int CLK_FREQ   = uart_pkg::CLK_FREQ_DEF,
  parameter int BAUD_RATE  = uart_pkg::BAUD_RATE_DEF,
  parameter int BIT_CYCLES = CLK_FREQ / BAUD_RATE
) (
  input  logic       s_clk,
  input  logic       s_rst_n,
  input  logic       data_in,
  output logic [7:0] data_rx,
  output logic       po_flag
);
  import uart_pkg::*;

  localparam int CW     = $clog2(BIT_CYCLES);
  localparam int SAMPLE = mid_point(BIT_CYCLES);

  logic            rx_s;
  logic            fall;
  rx_state_t       state;
  logic [CW-1:0]   baud_cnt;
  logic [3:0]      bit_cnt;
  logic [7:0]      shreg;
  logic            wrap;
  logic            mid;
  logic            data_bit;

  uart_rx_sync_edge u_sync (
    .clk   (s_clk),
    .rst_n (s_rst_n),
    .din   (data_in),
    .dout  (rx_s),
    .fall  (fall)
  );

  assign wrap = baud_cnt == CW'(BIT_CYCLES - 1);
  assign mid  = baud_cnt == CW'(SAMPLE);

  assign data_bit = bit_cnt >= 4'(START_BIT + 1) &&
                    bit_cnt <= 4'(DATA_BITS);

  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      data_rx  <= '0;
      po_flag  <= 1'b0;
    end else begin
      po_flag <= 1'b0;

      if (state != IDLE) begin
        baud_cnt <= wrap ? '0 : baud_cnt + 1'b1;
        if (wrap)
          bit_cnt <= bit_cnt + 1'b1;
      end

      unique case (state)
        IDLE: begin
          if (fall) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= START;
          end
        end

        // A high line at mid start bit is a glitch.
        START: begin
          if (mid) begin
            if (rx_s) begin
              baud_cnt <= '0;
              bit_cnt  <= '0;
              state    <= IDLE;
            end else begin
              state <= DATA;
            end
          end
        end

        DATA: begin
          if (mid && data_bit) begin
            shreg <= {rx_s, shreg[7:1]};
            if (bit_cnt == 4'(DATA_BITS))
              state <= STOP;
          end
        end

        // Leave at stop midpoint so a back-to-back
        // start bit is still caught.
        STOP: begin
          if (mid && bit_cnt == 4'(STOP_BIT)) begin
            if (rx_s) begin
              data_rx <= shreg;
              po_flag <= 1'b1;
            end
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx at a reduced bit period.
// Drives 8N1 frames and checks strobes, data and latency.
module tb_uart_rx;

  localparam int BITC = 64;
  localparam int TXF  = 63;
  localparam int LAT  = 9 * BITC + BITC / 2 + 3;

  logic       s_clk;
  logic       s_rst_n;
  logic       data_in;
  logic [7:0] data_rx;
  logic       po_flag;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int pulse_cnt = 0;
  int po_cyc = 0;
  int fall_cyc = 0;
  int base;
  bit wide_err = 0;
  bit prev_po = 0;
  logic [7:0] got[$];

  uart_rx #(
    .CLK_FREQ   (50_000_000),
    .BAUD_RATE  (781_250),
    .BIT_CYCLES (BITC)
  ) dut (
    .s_clk   (s_clk),
    .s_rst_n (s_rst_n),
    .data_in (data_in),
    .data_rx (data_rx),
    .po_flag (po_flag)
  );

  initial s_clk = 1'b0;
  always #10 s_clk = ~s_clk;

  always @(posedge s_clk) cyc <= cyc + 1;

  always @(negedge s_clk) begin
    if (po_flag === 1'b1) begin
      pulse_cnt = pulse_cnt + 1;
      po_cyc = cyc;
      got.push_back(data_rx);
      if (prev_po)
        wide_err = 1;
    end
    prev_po = (po_flag === 1'b1);
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge s_clk);
  endtask

  task automatic send(input logic [7:0] b,
                      input int bl,
                      input logic stop);
    data_in = 1'b0;
    fall_cyc = cyc;
    wait_cyc(bl);
    for (int i = 0; i < 8; i++) begin
      data_in = b[i];
      wait_cyc(bl);
    end
    data_in = stop;
    wait_cyc(bl);
    data_in = 1'b1;
  endtask

  function automatic logic [7:0] last_byte();
    if (got.size() == 0)
      return 8'hxx;
    return got[got.size() - 1];
  endfunction

  initial begin
    logic [7:0] c3;
    s_rst_n = 1'b0;
    data_in = 1'b1;
    wait_cyc(5);
    chk("reset_data_rx", 32'(data_rx), 32'h00);
    chk("reset_po_flag", 32'(po_flag), 32'h0);
    s_rst_n = 1'b1;

    wait_cyc(2000);
    chk("idle_pulses", 32'(pulse_cnt), 0);
    chk("idle_data_rx", 32'(data_rx), 32'h00);

    base = pulse_cnt;
    send(8'h55, TXF, 1'b1);
    send(8'hAA, TXF, 1'b1);
    send(8'h00, TXF, 1'b1);
    send(8'hFF, TXF, 1'b1);
    wait_cyc(200);
    chk("b2b_count", 32'(pulse_cnt - base), 4);
    if (pulse_cnt - base == 4) begin
      chk("b2b_0", 32'(got[base]), 32'h55);
      chk("b2b_1", 32'(got[base + 1]), 32'hAA);
      chk("b2b_2", 32'(got[base + 2]), 32'h00);
      chk("b2b_3", 32'(got[base + 3]), 32'hFF);
    end
    chk("b2b_width", 32'(wide_err), 0);

    base = pulse_cnt;
    send(8'hA5, BITC, 1'b1);
    wait_cyc(200);
    chk("a5_count", 32'(pulse_cnt - base), 1);
    chk("a5_data", 32'(last_byte()), 32'hA5);
    chk("a5_data_rx_hold", 32'(data_rx), 32'hA5);
    chk("a5_lat_ok",
        32'((po_cyc - fall_cyc >= LAT - 1) &&
            (po_cyc - fall_cyc <= LAT + 1)), 1);
    chk("a5_width", 32'(wide_err), 0);

    base = pulse_cnt;
    data_in = 1'b0;
    wait_cyc(12);
    data_in = 1'b1;
    wait_cyc(300);
    chk("glitch_no_pulse", 32'(pulse_cnt - base), 0);
    send(8'h3C, BITC, 1'b1);
    wait_cyc(200);
    chk("glitch_next_count", 32'(pulse_cnt - base), 1);
    chk("glitch_next_data", 32'(last_byte()), 32'h3C);

    base = pulse_cnt;
    send(8'h81, BITC, 1'b0);
    wait_cyc(200);
    chk("frame_err_no_pulse", 32'(pulse_cnt - base), 0);
    chk("frame_err_hold", 32'(data_rx), 32'h3C);
    send(8'h7E, BITC, 1'b1);
    wait_cyc(200);
    chk("frame_next_count", 32'(pulse_cnt - base), 1);
    chk("frame_next_data", 32'(data_rx), 32'h7E);

    base = pulse_cnt;
    c3 = 8'hC3;
    data_in = 1'b0;
    wait_cyc(BITC);
    for (int i = 0; i < 4; i++) begin
      data_in = c3[i];
      wait_cyc(BITC);
    end
    data_in = c3[4];
    wait_cyc(30);
    s_rst_n = 1'b0;
    data_in = 1'b1;
    wait_cyc(3);
    chk("rst_mid_data_rx", 32'(data_rx), 32'h00);
    chk("rst_mid_po", 32'(po_flag), 0);
    s_rst_n = 1'b1;
    wait_cyc(800);
    chk("rst_no_pulse", 32'(pulse_cnt - base), 0);
    chk("rst_data_rx", 32'(data_rx), 32'h00);
    send(8'h12, BITC, 1'b1);
    wait_cyc(200);
    chk("rst_next_count", 32'(pulse_cnt - base), 1);
    chk("rst_next_data", 32'(data_rx), 32'h12);
    chk("final_width", 32'(wide_err), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
